// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key encoder.
//   - Prefix byte values (E0 extended, F0 release, E1 pause).
//   - Bytes that are keyboard status/ack replies rather than key codes.
//   - Bit positions inside the 11-bit ps2_key event word.
//   - Prefix FSM state encoding and a non-key byte classifier.
package ps2_pkg;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_REL   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam int NUM_NON_KEY = 6;
    localparam logic [7:0] NON_KEY_BYTES [NUM_NON_KEY] =
        '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    typedef enum logic {
        PFX_IDLE = 1'b0,
        PFX_SKIP = 1'b1
    } pfx_state_t;

    // True for replies (BAT result, echo, ack, resend, error) that must
    // never be reported as a key.
    function automatic logic is_non_key(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_NON_KEY; i++) begin
            if (b == NON_KEY_BYTES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// Signal bundle between a PS/2 keyboard connection and the key encoder.
//   ps2_clk_in / ps2_data_in : raw, asynchronous keyboard lines
//   ps2_key                  : event word ([10] toggle, [9] pressed, [8] E0, [7:0] code)
//   frame_err                : one-cycle pulse on framing/parity/timeout error
//   busy                     : frame in progress
//   state_dbg                : prefix FSM state, for observation only
// master = keyboard side, slave = encoder.
interface ps2_key_encoder_if;
    import ps2_pkg::*;

    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;
    pfx_state_t  state_dbg;

    modport master (
        output ps2_clk_in, ps2_data_in,
        input  ps2_key, frame_err, busy, state_dbg
    );

    modport slave (
        input  ps2_clk_in, ps2_data_in,
        output ps2_key, frame_err, busy, state_dbg
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
//   clk_i, rst_i        : system clock, asynchronous active-high reset
//   ps2_clk_i/data_i    : raw keyboard lines (asynchronous)
//   byte_valid_o/byte_o : one-cycle strobe with a good byte
//   err_o               : one-cycle strobe on parity/stop/timeout error
//   busy_o              : start bit accepted, stop bit not yet processed
// byte_valid_o is a push-only strobe with no ready: the consumer must
// take the byte in the cycle the strobe is high.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       err_o,
    output logic       busy_o
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]     clk_sync_q, data_sync_q;
    logic           filt_q;
    logic [FCW-1:0] fcnt_q;
    logic [3:0]     bcnt_q;
    logic [8:0]     sr_q;     // [7:0] data, [8] parity once complete
    logic [TCW-1:0] tcnt_q;
    logic           byte_valid_q, err_q;
    logic [7:0]     byte_q;

    logic clk_s, data_s, filt_flip, fall, timeout;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    // The filtered clock only moves on the FILTER_LEN-th consecutive
    // sample that disagrees with it.
    assign filt_flip = (clk_s != filt_q) && (fcnt_q == FCW'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_q;
    assign timeout   = (bcnt_q != 4'd0) && !fall && (tcnt_q == TCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            bcnt_q       <= 4'd0;
            sr_q         <= '0;
            tcnt_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};

            if (clk_s == filt_q) begin
                fcnt_q <= '0;
            end else if (filt_flip) begin
                filt_q <= clk_s;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FCW'(1);
            end

            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;

            if (fall) begin
                tcnt_q <= '0;
                if (bcnt_q == 4'd0) begin
                    // A high start bit is line noise, not a frame.
                    if (!data_s) bcnt_q <= 4'd1;
                end else if (bcnt_q != 4'd10) begin
                    sr_q   <= {data_s, sr_q[8:1]};
                    bcnt_q <= bcnt_q + 4'd1;
                end else begin
                    bcnt_q <= 4'd0;
                    if ((^sr_q) && data_s) begin
                        byte_valid_q <= 1'b1;
                        byte_q       <= sr_q[7:0];
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end else if (bcnt_q != 4'd0) begin
                if (timeout) begin
                    bcnt_q <= 4'd0;
                    tcnt_q <= '0;
                    err_q  <= 1'b1;
                end else begin
                    tcnt_q <= tcnt_q + TCW'(1);
                end
            end else begin
                tcnt_q <= '0;
            end
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign err_o        = err_q;
    assign busy_o       = (bcnt_q != 4'd0);

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to ps2_key event word encoder.
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   bus     : slave side of ps2_key_encoder_if (raw lines in; ps2_key,
//             frame_err, busy, state_dbg out)
// Frame reception lives in ps2_frame_rx; this level folds E0/F0/E1
// prefixes into flags and emits one toggled event per make/break code.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000,
    parameter int PAUSE_SKIP  = 7
) (
    input  logic              clk_sys,
    input  logic              reset,
    ps2_key_encoder_if.slave  bus
);
    localparam int SKW = $clog2(PAUSE_SKIP + 1);

    logic       rx_valid, rx_err;
    logic [7:0] rx_byte;

    pfx_state_t  state_q, state_d;
    logic        ext_q, ext_d, rel_q, rel_d;
    logic [SKW-1:0] skip_q, skip_d;
    logic [10:0] key_q, key_d;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .ps2_clk_i   (bus.ps2_clk_in),
        .ps2_data_i  (bus.ps2_data_in),
        .byte_valid_o(rx_valid),
        .byte_o      (rx_byte),
        .err_o       (rx_err),
        .busy_o      (bus.busy)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= PFX_IDLE;
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            skip_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            skip_q  <= skip_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        rel_d   = rel_q;
        skip_d  = skip_q;
        key_d   = key_q;

        if (rx_err) begin
            // A damaged frame may have been a prefix; forget all context.
            state_d = PFX_IDLE;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end else if (rx_valid) begin
            case (state_q)
                PFX_IDLE: begin
                    if (rx_byte == PFX_EXT) begin
                        ext_d = 1'b1;
                    end else if (rx_byte == PFX_REL) begin
                        rel_d = 1'b1;
                    end else if (rx_byte == PFX_PAUSE) begin
                        // Pause sends a fixed tail of bytes that look like
                        // real keys; swallow them.
                        state_d = PFX_SKIP;
                        skip_d  = SKW'(PAUSE_SKIP);
                        ext_d   = 1'b0;
                        rel_d   = 1'b0;
                    end else begin
                        if (!is_non_key(rx_byte)) begin
                            key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
                            key_d[KEY_PRESSED] = ~rel_q;
                            key_d[KEY_EXT]     = ext_q;
                            key_d[7:0]         = rx_byte;
                        end
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end
                PFX_SKIP: begin
                    skip_d = skip_q - SKW'(1);
                    if (skip_q == SKW'(1)) state_d = PFX_IDLE;
                end
                default: state_d = PFX_IDLE;
            endcase
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = rx_err;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
module tb_ps2_key_encoder;
    import ps2_pkg::*;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 48000;
    localparam int PAUSE_SKIP  = 7;
    localparam int HALF        = 20;   // PS/2 half bit period in clk_sys cycles

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   fails   = 0;

    ps2_key_encoder_if bus();

    ps2_key_encoder #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .PAUSE_SKIP (PAUSE_SKIP)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic drive_bit(input logic b);
        bus.ps2_data_in = b;
        cycles(HALF);
        bus.ps2_clk_in = 1'b0;
        cycles(HALF);
        bus.ps2_clk_in = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par,
                                               input logic stop);
        return {stop, (~(^b)) ^ bad_par, b, 1'b0};
    endfunction

    // Drives a frame up to the 11th falling clock and returns at the first
    // negedge where busy has dropped (key not yet updated there).
    task automatic send_head(input logic [7:0] b, input logic bad_par, input logic stop);
        logic [10:0] f;
        bit ok;
        f = frame_bits(b, bad_par, stop);
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        bus.ps2_data_in = f[10];
        cycles(HALF);
        bus.ps2_clk_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4 * HALF && !ok; i++) begin
            @(negedge clk_sys);
            if (bus.busy === 1'b0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL frame_done byte %h: busy still %b after 11th edge, want 0", b, bus.busy);
        end
    endtask

    task automatic send_tail();
        cycles(HALF);
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        cycles(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b, 1'b0, 1'b1);
        send_tail();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        reset = 1'b1;
        cycles(4);
        checks++; if (bus.ps2_key !== 11'h000) begin fails++; $display("FAIL reset_key: got %h want 000", bus.ps2_key); end
        checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        reset = 1'b0;
        cycles(4);
        checks++; if (bus.state_dbg !== PFX_IDLE) begin fails++; $display("FAIL reset_state: got %b want IDLE", bus.state_dbg); end
        checks++; if (bus.ps2_key !== 11'h000) begin fails++; $display("FAIL post_reset_key: got %h want 000", bus.ps2_key); end
    endtask

    task automatic test_single_make();
        send_head(8'h29, 1'b0, 1'b1);
        checks++; if (bus.ps2_key !== 11'h000) begin fails++; $display("FAIL make_latency_early: got %h want 000", bus.ps2_key); end
        checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL make_err: got %b want 0", bus.frame_err); end
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h629) begin fails++; $display("FAIL make_key: got %h want 629", bus.ps2_key); end
        checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL make_err_late: got %b want 0", bus.frame_err); end
        send_tail();
    endtask

    task automatic test_break_ext();
        send_byte(8'hE0);
        checks++; if (bus.ps2_key !== 11'h629) begin fails++; $display("FAIL e0_no_event: got %h want 629", bus.ps2_key); end
        send_byte(8'hF0);
        checks++; if (bus.ps2_key !== 11'h629) begin fails++; $display("FAIL f0_no_event: got %h want 629", bus.ps2_key); end
        send_head(8'h75, 1'b0, 1'b1);
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h175) begin fails++; $display("FAIL break_ext_key: got %h want 175", bus.ps2_key); end
        send_tail();
        cycles(50);
        checks++; if (bus.ps2_key !== 11'h175) begin fails++; $display("FAIL key_hold: got %h want 175", bus.ps2_key); end
    endtask

    task automatic test_parity_err();
        send_byte(8'hE0);
        send_head(8'h6B, 1'b1, 1'b1);
        checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL parity_err_pulse: got %b want 1", bus.frame_err); end
        cycles(1);
        checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL parity_err_width: got %b want 0", bus.frame_err); end
        checks++; if (bus.ps2_key !== 11'h175) begin fails++; $display("FAIL parity_no_event: got %h want 175", bus.ps2_key); end
        send_tail();
        send_head(8'h6B, 1'b0, 1'b0);
        checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL stop_err_pulse: got %b want 1", bus.frame_err); end
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h175) begin fails++; $display("FAIL stop_no_event: got %h want 175", bus.ps2_key); end
        send_tail();
        send_head(8'h6B, 1'b0, 1'b1);
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h66B) begin fails++; $display("FAIL after_err_key: got %h want 66B", bus.ps2_key); end
        send_tail();
    endtask

    task automatic test_glitch_timeout();
        logic [10:0] f;
        bit ok;
        int n;
        bus.ps2_data_in = 1'b0;
        cycles(HALF);
        bus.ps2_clk_in = 1'b0;
        cycles(3);
        bus.ps2_clk_in = 1'b1;
        cycles(30);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_no_edge: busy got %b want 0", bus.busy); end
        bus.ps2_data_in = 1'b1;
        cycles(HALF);
        drive_bit(1'b1);
        cycles(10);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL start_one_ignored: busy got %b want 0", bus.busy); end
        f = frame_bits(8'h16, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive_bit(f[i]);
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL partial_busy: got %b want 1", bus.busy); end
        ok = 1'b0;
        n  = 0;
        while (!ok && n < TIMEOUT_CYC + 200) begin
            @(negedge clk_sys);
            n++;
            if (bus.busy === 1'b0) ok = 1'b1;
        end
        checks++; if (!ok) begin fails++; $display("FAIL timeout_fires: busy got %b want 0", bus.busy); end
        checks++; if (n < TIMEOUT_CYC - 2 * HALF) begin fails++; $display("FAIL timeout_early: after %0d cycles want >= %0d", n, TIMEOUT_CYC - 2 * HALF); end
        checks++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", bus.frame_err); end
        cycles(1);
        checks++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL timeout_err_width: got %b want 0", bus.frame_err); end
        checks++; if (bus.ps2_key !== 11'h66B) begin fails++; $display("FAIL timeout_no_event: got %h want 66B", bus.ps2_key); end
        cycles(HALF);
        send_head(8'h16, 1'b0, 1'b1);
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h216) begin fails++; $display("FAIL post_timeout_key: got %h want 216", bus.ps2_key); end
        send_tail();
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) begin
            send_byte(seq[i]);
            checks++; if (bus.ps2_key !== 11'h216) begin fails++; $display("FAIL pause_no_event[%0d]: got %h want 216", i, bus.ps2_key); end
            if (i == 0) begin
                checks++; if (bus.state_dbg !== PFX_SKIP) begin fails++; $display("FAIL pause_enter_skip: got %b want SKIP", bus.state_dbg); end
            end
        end
        checks++; if (bus.state_dbg !== PFX_IDLE) begin fails++; $display("FAIL pause_exit_skip: got %b want IDLE", bus.state_dbg); end
        send_head(8'h05, 1'b0, 1'b1);
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h605) begin fails++; $display("FAIL post_pause_key: got %h want 605", bus.ps2_key); end
        send_tail();
    endtask

    task automatic test_prefix_order();
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'hE0);
        checks++; if (bus.ps2_key !== 11'h605) begin fails++; $display("FAIL prefix_no_event: got %h want 605", bus.ps2_key); end
        send_head(8'h5A, 1'b0, 1'b1);
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h15A) begin fails++; $display("FAIL f0_e0_e0_key: got %h want 15A", bus.ps2_key); end
        send_tail();
    endtask

    task automatic test_non_key();
        send_byte(8'hE0);
        send_byte(8'hAA);
        checks++; if (bus.ps2_key !== 11'h15A) begin fails++; $display("FAIL nonkey_no_event: got %h want 15A", bus.ps2_key); end
        send_head(8'h34, 1'b0, 1'b1);
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h634) begin fails++; $display("FAIL nonkey_clears_ext: got %h want 634", bus.ps2_key); end
        send_tail();
    endtask

    task automatic test_reset_mid();
        logic [10:0] f;
        f = frame_bits(8'h1C, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) drive_bit(f[i]);
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        reset = 1'b1;
        #1;
        checks++; if (bus.ps2_key !== 11'h000) begin fails++; $display("FAIL mid_reset_key: got %h want 000", bus.ps2_key); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b want 0", bus.busy); end
        @(negedge clk_sys);
        reset = 1'b0;
        bus.ps2_data_in = 1'b1;
        cycles(HALF);
        send_head(8'h1C, 1'b0, 1'b1);
        cycles(1);
        checks++; if (bus.ps2_key !== 11'h61C) begin fails++; $display("FAIL post_reset_frame: got %h want 61C", bus.ps2_key); end
        send_tail();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        test_reset();
        test_single_make();
        test_break_ext();
        test_parity_err();
        test_glitch_timeout();
        test_pause();
        test_prefix_order();
        test_non_key();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
